burst_ctrl: RTL and testbench

BURST_CTRL -- requirements
Module: burst_ctrl

---
 rtl/burst_ctrl_if.sv | 21 ++
 rtl/burst_ctrl.sv | 116 +++++++++++
 tb/tb_burst_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_ctrl_if.sv
// Requester-side bus of the burst controller: request/beat inputs and
// grant/status outputs grouped so the controller takes a single port.
interface burst_ctrl_if;
    logic [1:0] req;
    logic       data_valid;
    logic [1:0] gnt;
    logic       busy;
    logic [5:0] cnt;
    logic       done;
    logic       abort;

    modport master (
        output req, data_valid,
        input  gnt, busy, cnt, done, abort
    );

    modport slave (
        input  req, data_valid,
        output gnt, busy, cnt, done, abort
    );
endinterface

// File: rtl/burst_ctrl.sv
// Two-requester round-robin burst controller. The winner owns a shared
// beat counter for BURST_LEN beats; dropping its request aborts the burst.
//
//   state | meaning
//   IDLE  | no owner, arbitrate any request
//   BURST | owner granted, counting data_valid beats
//   DONE  | one-cycle completion pulse, grant released
//   ABORT | one-cycle abort pulse, grant released
module burst_ctrl #(
    parameter int BURST_LEN = 33
) (
    input  logic         clk,
    input  logic         rst,
    burst_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BURST, DONE, ABORT} state_t;

    localparam logic [5:0] LAST_CNT = 6'(BURST_LEN - 1);

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       abort_q, abort_d;
    logic [5:0] cnt_q, cnt_d;
    logic       last_q, last_d;   // last owner; equals current owner during BURST

    logic       win;
    logic       owner_req;
    logic       last_beat;

    assign win       = (bus.req == 2'b11) ? ~last_q : ~bus.req[0];
    assign owner_req = bus.req[last_q];
    assign last_beat = bus.data_valid && (cnt_q == LAST_CNT);

    // State and registered outputs; reset parks last owner at 1 so requester 0 wins first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= 6'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state: losing the owner request outranks a beat in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req != 2'b00) state_d = BURST;
            BURST: begin
                if (!owner_req)     state_d = ABORT;
                else if (last_beat) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the output registers, cnt held outside of grants and beats
    always_comb begin
        gnt_d   = gnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    gnt_d  = win ? 2'b10 : 2'b01;
                    busy_d = 1'b1;
                    cnt_d  = 6'd0;
                    last_d = win;
                end else begin
                    gnt_d = 2'b00;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    gnt_d   = 2'b00;
                    abort_d = 1'b1;
                end else if (bus.data_valid) begin
                    cnt_d = cnt_q + 6'd1;
                    if (last_beat) begin
                        gnt_d  = 2'b00;
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: gnt_d = 2'b00;
        endcase
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.abort = abort_q;
    assign bus.cnt   = cnt_q;

endmodule

// File: tb/tb_burst_ctrl.sv
// Bench for burst_ctrl: a BURST_LEN=33 and a BURST_LEN=1 instance share
// stimulus; both are compared every cycle against a behavioural model.
module tb_burst_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    burst_ctrl_if bus0();
    burst_ctrl_if bus1();

    burst_ctrl #(.BURST_LEN(33)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    burst_ctrl #(.BURST_LEN(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int total = 0;
    int bad   = 0;

    // model: owner -1 = nobody, cool = in the single pulse cycle after a burst
    int m_len [2] = '{33, 1};
    int m_owner [2];
    int m_cool [2];
    int m_cnt [2];
    int m_last [2];
    int m_done [2];
    int m_abort [2];

    logic [1:0] cur_req = 2'b00;
    logic       cur_dv  = 1'b0;

    typedef struct {
        logic [1:0] req;
        logic       dv;
        int         gnt;
        int         busy;
        int         cnt;
        int         done;
        int         abort;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_cool[k] = 0; m_cnt[k] = 0;
            m_last[k] = 1;   m_done[k] = 0; m_abort[k] = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] r, input logic d);
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 0;
            m_abort[k] = 0;
            if (m_cool[k] != 0) begin
                m_cool[k] = 0;
            end else if (m_owner[k] < 0) begin
                if (r != 2'b00) begin
                    if (r == 2'b11) m_owner[k] = 1 - m_last[k];
                    else            m_owner[k] = r[0] ? 0 : 1;
                    m_last[k] = m_owner[k];
                    m_cnt[k]  = 0;
                end
            end else if (!r[m_owner[k]]) begin
                m_abort[k] = 1; m_owner[k] = -1; m_cool[k] = 1;
            end else if (d) begin
                m_cnt[k]++;
                if (m_cnt[k] == m_len[k]) begin
                    m_done[k] = 1; m_owner[k] = -1; m_cool[k] = 1;
                end
            end
        end
    endtask

    function automatic int exp_gnt(input int k);
        return (m_owner[k] < 0) ? 0 : (1 << m_owner[k]);
    endfunction

    task automatic check_all();
        check("m0.gnt",   int'(bus0.gnt),   exp_gnt(0));
        check("m0.busy",  int'(bus0.busy),  (m_owner[0] >= 0) ? 1 : 0);
        check("m0.cnt",   int'(bus0.cnt),   m_cnt[0]);
        check("m0.done",  int'(bus0.done),  m_done[0]);
        check("m0.abort", int'(bus0.abort), m_abort[0]);
        check("m1.gnt",   int'(bus1.gnt),   exp_gnt(1));
        check("m1.busy",  int'(bus1.busy),  (m_owner[1] >= 0) ? 1 : 0);
        check("m1.cnt",   int'(bus1.cnt),   m_cnt[1]);
        check("m1.done",  int'(bus1.done),  m_done[1]);
        check("m1.abort", int'(bus1.abort), m_abort[1]);
    endtask

    task automatic drive(input logic [1:0] r, input logic d);
        cur_req = r; cur_dv = d;
        bus0.req = r; bus0.data_valid = d;
        bus1.req = r; bus1.data_valid = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step(cur_req, cur_dv);
        check_all();
    endtask

    task automatic do_reset();
        drive(2'b00, 1'b0);
        rst = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vecs [12];

    initial begin
        int n;
        int dones;
        int busy_cycles;
        int prev_busy;
        int grants [$];
        logic [1:0] r;

        vecs[0]  = '{2'b00, 1'b0, 0, 0, 0, 0, 0};
        vecs[1]  = '{2'b10, 1'b1, 2, 1, 0, 0, 0};
        vecs[2]  = '{2'b10, 1'b1, 0, 0, 1, 1, 0};
        vecs[3]  = '{2'b10, 1'b1, 0, 0, 1, 0, 0};
        vecs[4]  = '{2'b11, 1'b0, 1, 1, 0, 0, 0};
        vecs[5]  = '{2'b11, 1'b0, 1, 1, 0, 0, 0};
        vecs[6]  = '{2'b10, 1'b1, 0, 0, 0, 0, 1};
        vecs[7]  = '{2'b00, 1'b0, 0, 0, 0, 0, 0};
        vecs[8]  = '{2'b11, 1'b1, 2, 1, 0, 0, 0};
        vecs[9]  = '{2'b11, 1'b1, 0, 0, 1, 1, 0};
        vecs[10] = '{2'b01, 1'b0, 0, 0, 1, 0, 0};
        vecs[11] = '{2'b01, 1'b0, 1, 1, 0, 0, 0};

        drive(2'b00, 1'b0);
        #1;
        do_reset();

        // table on the BURST_LEN=1 instance
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].req, vecs[i].dv);
            tick();
            check($sformatf("tbl%0d.gnt", i),   int'(bus1.gnt),   vecs[i].gnt);
            check($sformatf("tbl%0d.busy", i),  int'(bus1.busy),  vecs[i].busy);
            check($sformatf("tbl%0d.cnt", i),   int'(bus1.cnt),   vecs[i].cnt);
            check($sformatf("tbl%0d.done", i),  int'(bus1.done),  vecs[i].done);
            check($sformatf("tbl%0d.abort", i), int'(bus1.abort), vecs[i].abort);
        end

        // single owner, continuous beats
        do_reset();
        drive(2'b01, 1'b1);
        tick();
        check("full.gnt_latency", int'(bus0.gnt), 1);
        check("full.cnt_start", int'(bus0.cnt), 0);
        n = 0;
        while (bus0.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("full.done_after_beats", n, 33);
        check("full.gnt_in_done", int'(bus0.gnt), 0);
        check("full.cnt_in_done", int'(bus0.cnt), 33);
        drive(2'b00, 1'b0);
        tick();
        check("full.done_one_cycle", int'(bus0.done), 0);
        tick();
        check("full.cnt_hold", int'(bus0.cnt), 33);

        // round-robin over three bursts with both requesting
        do_reset();
        drive(2'b11, 1'b1);
        dones = 0;
        prev_busy = 0;
        for (int i = 0; i < 105; i++) begin
            tick();
            if (bus0.busy && prev_busy == 0) grants.push_back(int'(bus0.gnt));
            if (bus0.done) begin
                dones++;
                check("rr.cnt_at_done", int'(bus0.cnt), 33);
            end
            prev_busy = int'(bus0.busy);
        end
        check("rr.dones", dones, 3);
        check("rr.grants", grants.size(), 3);
        if (grants.size() == 3) begin
            check("rr.g0", grants[0], 1);
            check("rr.g1", grants[1], 2);
            check("rr.g2", grants[2], 1);
        end

        // gapped beats: valid every other cycle
        do_reset();
        drive(2'b01, 1'b0);
        tick();
        busy_cycles = int'(bus0.busy);
        n = 0;
        while (bus0.done !== 1'b1 && n < 200) begin
            drive(2'b01, n[0]);
            tick();
            if (bus0.busy) busy_cycles++;
            n++;
        end
        check("gap.done_seen", int'(bus0.done), 1);
        check("gap.busy_cycles", busy_cycles, 66);

        // owner drops request together with a valid beat at cnt=10
        do_reset();
        drive(2'b01, 1'b1);
        tick();
        n = 0;
        while (m_cnt[0] != 10 && n < 50) begin tick(); n++; end
        check("abt.reach10", int'(bus0.cnt), 10);
        drive(2'b10, 1'b1);
        tick();
        check("abt.abort", int'(bus0.abort), 1);
        check("abt.done", int'(bus0.done), 0);
        check("abt.cnt", int'(bus0.cnt), 10);
        check("abt.gnt", int'(bus0.gnt), 0);
        drive(2'b00, 1'b0);
        tick();
        check("abt.pulse_one", int'(bus0.abort), 0);
        check("abt.cnt_hold", int'(bus0.cnt), 10);

        // asynchronous reset mid-burst, between clock edges
        do_reset();
        drive(2'b01, 1'b1);
        tick();
        n = 0;
        while (m_cnt[0] != 20 && n < 50) begin tick(); n++; end
        check("ars.reach20", int'(bus0.cnt), 20);
        #2;
        rst = 1'b0;
        #1;
        check("ars.gnt", int'(bus0.gnt), 0);
        check("ars.busy", int'(bus0.busy), 0);
        check("ars.cnt", int'(bus0.cnt), 0);
        model_reset();
        drive(2'b10, 1'b0);
        @(negedge clk);
        check("ars.no_pulse", int'(bus0.done | bus0.abort), 0);
        rst = 1'b1;
        tick();
        check("ars.regrant", int'(bus0.gnt), 2);

        // random traffic against the model
        do_reset();
        r = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) r = 2'($urandom_range(0, 3));
            drive(r, $urandom_range(0, 3) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
